// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 host front end: command encodings,
// field widths, queue depth defaults and the packed command-queue entry.
package ddr2_pkg;

    localparam int CMD_W          = 3;
    localparam int SZ_W           = 2;
    localparam int OP_W           = 3;
    localparam int ADDR_W         = 25;
    localparam int DATA_W         = 16;
    localparam int BEAT_W         = 5;
    localparam int CMD_DEPTH_DEF  = 16;
    localparam int DATA_DEPTH_DEF = 64;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_NOP7 = 3'd7
    } cmd_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [SZ_W-1:0]   sz;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

    // A block is 8*(sz+1) words; after the first beat 8*(sz+1)-1 remain,
    // which is simply sz followed by three ones.
    function automatic logic [BEAT_W-1:0] blk_remaining(input logic [SZ_W-1:0] sz);
        return {sz, 3'b111};
    endfunction

endpackage

// File: rtl/ddr2_sync_fifo.sv
// Single-clock FIFO with registered storage, combinational head select and
// registered count/empty/full flags; pointers wrap modulo DEPTH.
module ddr2_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, full_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Stale storage is masked so an empty queue always presents zero.
    assign dout_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/ddr2_host_frontend.sv
// Host-side front end of the DDR2 controller: accepts host commands and write
// data into a command queue and a write-data queue, collecting block-write beats.
module ddr2_host_frontend
    import ddr2_pkg::*;
#(
    parameter int CMD_DEPTH  = CMD_DEPTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INIT_DONE,
    input  logic [CMD_W-1:0]    CMD,
    input  logic [SZ_W-1:0]     SZ,
    input  logic [OP_W-1:0]     OP,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   DIN,
    output logic                NOTFULL,
    output logic [6:0]          FILLCOUNT,
    output logic                CQ_VALID,
    output logic [ENTRY_W-1:0]  CQ_DATA,
    input  logic                CQ_POP,
    output logic                DQ_VALID,
    output logic [DATA_W-1:0]   DQ_DATA,
    input  logic                DQ_POP,
    output logic                BLK_BUSY
);

    localparam int CQ_CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int DQ_CNT_W = $clog2(DATA_DEPTH + 1);

    typedef enum logic {ST_IDLE, ST_BLK} state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic                notfull_q, notfull_d;
    logic                cq_push, dq_push, cq_pop_eff;
    logic                cq_space, dq_space;
    logic [CQ_CNT_W-1:0] cq_count;
    logic [DQ_CNT_W-1:0] dq_count;
    logic                cq_empty, cq_full, dq_empty, dq_full;
    cmd_entry_t          cq_din;
    logic [ENTRY_W-1:0]  cq_dout;

    assign cq_space   = (cq_count < CQ_CNT_W'(CMD_DEPTH));
    assign dq_space   = !dq_full;
    assign cq_pop_eff = CQ_POP && !cq_empty;
    assign cq_din     = '{cmd: CMD, sz: SZ, op: OP, addr: ADDR};

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        cq_push = 1'b0;
        dq_push = 1'b0;
        if (INIT_DONE) begin
            case (state_q)
                ST_IDLE: begin
                    case (cmd_e'(CMD))
                        CMD_SCR, CMD_BLR: cq_push = cq_space;
                        CMD_SCW, CMD_ATR, CMD_ATW: begin
                            cq_push = cq_space && dq_space;
                            dq_push = cq_space && dq_space;
                        end
                        CMD_BLW: begin
                            if (cq_space && dq_space) begin
                                cq_push = 1'b1;
                                dq_push = 1'b1;
                                beats_d = blk_remaining(SZ);
                                state_d = ST_BLK;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_BLK: begin
                    if (dq_space) begin
                        dq_push = 1'b1;
                        beats_d = beats_q - BEAT_W'(1);
                        if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTFULL tracks the occupancy the command queue will have after this edge.
    always_comb begin
        if (cq_full) begin
            notfull_d = INIT_DONE && cq_pop_eff;
        end else begin
            notfull_d = INIT_DONE &&
                        !((cq_count == CQ_CNT_W'(CMD_DEPTH - 1)) && cq_push && !cq_pop_eff);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            beats_q   <= '0;
            notfull_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            notfull_q <= notfull_d;
        end
    end

    ddr2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (CLK),
        .srst    (RESET),
        .push_i  (cq_push),
        .din_i   (cq_din),
        .pop_i   (CQ_POP),
        .dout_o  (cq_dout),
        .count_o (cq_count),
        .empty_o (cq_empty),
        .full_o  (cq_full)
    );

    ddr2_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk     (CLK),
        .srst    (RESET),
        .push_i  (dq_push),
        .din_i   (DIN),
        .pop_i   (DQ_POP),
        .dout_o  (DQ_DATA),
        .count_o (dq_count),
        .empty_o (dq_empty),
        .full_o  (dq_full)
    );

    assign NOTFULL   = notfull_q;
    assign FILLCOUNT = 7'(dq_count);
    assign CQ_VALID  = !cq_empty;
    assign CQ_DATA   = cq_dout;
    assign DQ_VALID  = !dq_empty;
    assign BLK_BUSY  = (state_q == ST_BLK);

endmodule
